// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8-bit UART receiver with a small first-word-fall-through FIFO.
//
// The serial line is brought into the CLK domain through two flops. While a
// frame is in flight, a baud-tick generator runs Oversample ticks per bit.
// Each bit is taken as a 2-of-3 vote around mid-bit. Accepted bytes go into a
// FIFO that the consumer drains through a valid/ready handshake.
//
// Build option:
//   UART_RX_PARITY_EN - when defined, an even-parity bit follows data bit 7.
//                       A parity mismatch drops the byte and raises a frame
//                       error. When undefined, the receiver is plain 8N1.
//
// Ports:
//   CLK          system clock
//   RST          synchronous reset, active-low
//   i_rx         serial input, idle high, asynchronous to CLK
//   o_data       byte at the FIFO head
//   o_valid      FIFO not empty
//   i_ready      consumer takes o_data this cycle (pop when o_valid & i_ready)
//   o_frame_err  1-cycle pulse: bad stop bit (or bad parity)
//   o_overrun    1-cycle pulse: good byte dropped because the FIFO was full
//   o_busy       receiver FSM is not idle
module uart_rx_fifo #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRateUART   = 115200,
  parameter int Oversample     = 16,
  parameter int FifoDepth      = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int Div   = ClockFrequency / (BaudRateUART * Oversample);
  localparam int TickW = (Div > 1) ? $clog2(Div) : 1;
  localparam int OsW   = $clog2(Oversample);
  localparam int AddrW = $clog2(FifoDepth);

  localparam logic [TickW-1:0] TickLast = TickW'(Div - 1);
  localparam logic [OsW-1:0]   OsLast   = OsW'(Oversample - 1);
  localparam logic [OsW-1:0]   OsSamp0  = OsW'(Oversample / 2 - 1);
  localparam logic [OsW-1:0]   OsSamp1  = OsW'(Oversample / 2);
  localparam logic [OsW-1:0]   OsDecide = OsW'(Oversample / 2 + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser (reset to the idle line level)
  // ---------------------------------------------------------------------------
  logic rx_meta_q;
  logic rx_s_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Baud tick and oversample counters
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [TickW-1:0] tick_cnt_q;
  logic [OsW-1:0]   os_cnt_q;
  logic [1:0]       samp_q;
  logic             tick;
  logic             decide;
  logic             bit_val;
  logic             stop_ok;

  assign tick    = (state_q != StIdle) && (tick_cnt_q == TickLast);
  assign decide  = tick && (os_cnt_q == OsDecide);
  // 2-of-3 vote: two earlier samples plus the line value at the decision tick.
  assign bit_val = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  // The oversample counter runs freely modulo Oversample from the start edge.
  // Every bit decision therefore lands exactly Oversample ticks after the last.
  // The state also changes at the decision tick, not at the bit boundary.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
      samp_q     <= 2'b11;
    end else if (state_q == StIdle) begin
      // Held at zero so the bit phase restarts at every start edge.
      tick_cnt_q <= '0;
      os_cnt_q   <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
      os_cnt_q   <= (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsW'(1);
      if (os_cnt_q == OsSamp0) samp_q[0] <= rx_s_q;
      if (os_cnt_q == OsSamp1) samp_q[1] <= rx_s_q;
    end else begin
      tick_cnt_q <= tick_cnt_q + TickW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       frame_err_q;
  logic       push;

`ifdef UART_RX_PARITY_EN
  logic par_err_q;
  assign stop_ok = bit_val & ~par_err_q;
`else
  assign stop_ok = bit_val;
`endif

  assign push = (state_q == StStop) && decide && stop_ok;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!rx_s_q) state_q <= StStart;
        end
        StStart: begin
          if (decide) begin
            // A start bit that votes high was a glitch: drop it silently.
            if (bit_val) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
        end
        StData: begin
          if (decide) begin
            shift_q   <= {bit_val, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (decide) begin
            // Even parity: the parity bit equals the XOR of the data bits.
            par_err_q <= bit_val ^ (^shift_q);
            state_q   <= StStop;
          end
        end
`endif
        StStop: begin
          if (decide) begin
            frame_err_q <= ~stop_ok;
            // A low stop bit is a line break: wait for the line to recover.
            state_q     <= bit_val ? StIdle : StBreak;
          end
        end
        StBreak: begin
          if (rx_s_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [7:0]     mem_q [FifoDepth];
  logic [AddrW:0] wr_ptr_q;
  logic [AddrW:0] rd_ptr_q;
  logic           fifo_empty;
  logic           fifo_full;
  logic           pop;
  logic           wr_en;
  logic           overrun_q;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign pop        = ~fifo_empty & i_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en      = push & (~fifo_full | pop);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
    end else begin
      overrun_q <= push & fifo_full & ~pop;
      if (wr_en) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= shift_q;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign o_data      = mem_q[rd_ptr_q[AddrW-1:0]];
  assign o_valid     = ~fifo_empty;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo. It drives serial frames and compares the
// received byte stream and the error-pulse counts with a queue-based model.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 115200;
  localparam int OS     = 16;
  localparam int DEPTH  = 4;
  localparam int BIT    = (CLK_HZ / (BAUD * OS)) * OS;  // 432 CLK per bit
`ifdef UART_RX_PARITY_EN
  localparam int NRAND  = 1;
`else
  localparam int NRAND  = 3;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  always #5 CLK = ~CLK;

  uart_rx_fifo #(
    .ClockFrequency(CLK_HZ),
    .BaudRateUART  (BAUD),
    .Oversample    (OS),
    .FifoDepth     (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: bytes handed over, pulse counts, cycles with o_valid high.
  logic [7:0] got_q[$];
  int fe_cnt    = 0;
  int ov_cnt    = 0;
  int valid_cyc = 0;

  always @(negedge CLK) begin
    if (RST) begin
      if (o_valid && i_ready) got_q.push_back(o_data);
      if (o_frame_err) fe_cnt++;
      if (o_overrun) ov_cnt++;
      if (o_valid) valid_cyc++;
    end
  end

  // Reference model: hold_q is the FIFO content while the consumer stalls.
  // exp_q is the expected order of bytes handed to the consumer.
  logic [7:0] exp_q[$];
  logic [7:0] hold_q[$];
  int exp_fe = 0;
  int exp_ov = 0;

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (i_ready) begin
      while (hold_q.size() > 0) exp_q.push_back(hold_q.pop_front());
      if (good) exp_q.push_back(b);
    end else if (good) begin
      if (hold_q.size() == DEPTH) exp_ov++;
      else hold_q.push_back(b);
    end
    if (!good) exp_fe++;
  endtask

  task automatic drive(input logic v, input int n);
    i_rx = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_bit, input bit par_flip);
    bit good;
    good = stop_bit;
`ifdef UART_RX_PARITY_EN
    good = good && !par_flip;
`endif
    $display("frame byte=0x%02h stop=%0d par_flip=%0d ready=%0d", b, stop_bit, par_flip, i_ready);
    model_frame(b, good);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
`ifdef UART_RX_PARITY_EN
    drive((^b) ^ par_flip, BIT);
`endif
    drive(stop_bit, BIT);
  endtask

  task automatic drain();
    i_ready = 1'b1;
    while (hold_q.size() > 0) exp_q.push_back(hold_q.pop_front());
    repeat (2 * DEPTH + 4) @(posedge CLK);
    #1;
  endtask

  task automatic compare_stream(input string tag);
    check($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_counts(input string tag);
    check($sformatf("%s_frame_err", tag), fe_cnt, exp_fe);
    check($sformatf("%s_overrun", tag), ov_cnt, exp_ov);
  endtask

  initial begin
    repeat (110000) @(posedge CLK);
    $display("FAIL watchdog cycles=110000 limit=110000");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    logic [7:0] rb;
    bit rstop;

    // Reset state
    RST = 1'b0;
    i_rx = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_overrun", o_overrun, 0);
    RST = 1'b1;
    repeat (5) @(posedge CLK);
    #1;

    // 1: single byte with the consumer ready
    i_ready = 1'b1;
    v0 = valid_cyc;
    send(8'hA5, 1'b1, 1'b0);
    drive(1'b1, 20);
    compare_stream("t1");
    check("t1_valid_cycles", valid_cyc - v0, 1);
    compare_counts("t1");

    // 2: back-to-back burst into a stalled consumer, fifth byte overruns
    i_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
    drive(1'b1, 20);
    check("t2_valid_held", o_valid, 1);
    check("t2_head", o_data, 8'h01);
    drain();
    compare_stream("t2");
    compare_counts("t2");

    // 3: short low glitch on an idle line
    v0 = valid_cyc;
    drive(1'b0, 50);
    check("t3_busy_in_glitch", o_busy, 1);
    drive(1'b0, 50);
    drive(1'b1, 400);
    check("t3_busy_after", o_busy, 0);
    check("t3_no_valid", valid_cyc - v0, 0);
    compare_counts("t3");

    // 4: bad stop bit followed by a long break, then a good byte
    send(8'h3C, 1'b0, 1'b0);
    drive(1'b0, 20 * BIT);
    check("t4_break_busy", o_busy, 1);
    drive(1'b1, BIT);
    check("t4_idle_after_break", o_busy, 0);
    send(8'h7E, 1'b1, 1'b0);
    drive(1'b1, 20);
    compare_stream("t4");
    compare_counts("t4");

    // 5: reset in the middle of a frame with a byte parked in the FIFO
    i_ready = 1'b0;
    send(8'h5A, 1'b1, 1'b0);
    drive(1'b1, 20);
    check("t5_parked_valid", o_valid, 1);
    $display("frame byte=0xff partial, reset mid-data");
    drive(1'b0, BIT);
    drive(1'b1, BIT + BIT / 2);
    check("t5_busy_mid_data", o_busy, 1);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    hold_q.delete();
    check("t5_rst_valid", o_valid, 0);
    check("t5_rst_data", o_data, 0);
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_frame_err", o_frame_err, 0);
    check("t5_rst_overrun", o_overrun, 0);
    drive(1'b1, 7 * BIT);
    i_ready = 1'b1;
    send(8'h42, 1'b1, 1'b0);
    drive(1'b1, 20);
    compare_stream("t5");
    compare_counts("t5");

    // Randomized frames: random data, stall state and stop-bit errors
    for (int n = 0; n < NRAND; n++) begin
      i_ready = 1'($urandom_range(0, 1));
      rb      = 8'($urandom);
      rstop   = ($urandom_range(0, 3) != 0);
      send(rb, rstop, 1'b0);
      drive(1'b1, $urandom_range(8, BIT));
    end
    drain();
    compare_stream("rand");
    compare_counts("rand");

`ifdef UART_RX_PARITY_EN
    // 6: correct parity accepted, flipped parity rejected
    i_ready = 1'b1;
    send(8'h03, 1'b1, 1'b0);
    send(8'h03, 1'b1, 1'b1);
    drive(1'b1, 20);
    compare_stream("t6");
    compare_counts("t6");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
